// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the set-associative data cache controller:
//   - state_e     : controller FSM encoding
//   - clog2       : ceiling log2 used to derive field widths from parameters
//   - way_width   : width of a way number / age value (at least 1 bit)
//   - addr_field  : extracts a bit field from a byte address
// No ports (package).
// -----------------------------------------------------------------------------
package dcache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MISS,
      ST_WRITEBACK,
      ST_REFILL,
      ST_FILLED
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // A direct-mapped cache still needs a one-bit way/age signal.
   function automatic int way_width(input int ways);
      return (clog2(ways) < 1) ? 1 : clog2(ways);
   endfunction

   function automatic logic [31:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
      return 32'((addr >> lsb) & ((64'd1 << width) - 64'd1));
   endfunction

endpackage

// File: rtl/dcache_sa_ctrl_if.sv
// -----------------------------------------------------------------------------
// dcache_sa_ctrl_if
// Bundles the CPU MEM-stage port (p1_*) and the 256-bit memory port (mem_*)
// of the data cache. Signal suffixes are seen from the cache side.
//   slave  : the cache (consumes *_i, drives *_o)
//   master : the CPU/memory environment
// Parameters: ADDR_W (byte address width), LINE_W (line / memory data width).
// -----------------------------------------------------------------------------
interface dcache_sa_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   logic [LINE_W-1:0] mem_data_i;
   logic              mem_ack_i;
   logic [LINE_W-1:0] mem_data_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_enable_o;
   logic              mem_write_o;
   logic [31:0]       p1_data_i;
   logic [ADDR_W-1:0] p1_addr_i;
   logic              p1_MemRead_i;
   logic              p1_MemWrite_i;
   logic [31:0]       p1_data_o;
   logic              p1_stall_o;

   modport slave (
      input  mem_data_i, mem_ack_i, p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i,
      output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o, p1_data_o, p1_stall_o
   );

   modport master (
      output mem_data_i, mem_ack_i, p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i,
      input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o, p1_data_o, p1_stall_o
   );
endinterface

// File: rtl/dcache_lru_age.sv
// -----------------------------------------------------------------------------
// dcache_lru_age
// True-LRU bookkeeping: one age per way per set (0 = most recently used).
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset (ages become w)
//   upd_i        : touch way_i of set_i this cycle (hit or fill)
//   set_i        : set being accessed / updated
//   way_i        : way being touched
//   valid_i      : valid bits of set_i, used for victim choice
//   victim_o     : lowest-index invalid way, else the oldest way
// Parameters: SETS, WAYS.
// -----------------------------------------------------------------------------
module dcache_lru_age
   import dcache_pkg::*;
#(
   parameter int SETS = 32,
   parameter int WAYS = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             upd_i,
   input  logic [clog2(SETS)-1:0]           set_i,
   input  logic [way_width(WAYS)-1:0]       way_i,
   input  logic [WAYS-1:0]                  valid_i,
   output logic [way_width(WAYS)-1:0]       victim_o
);
   localparam int WAY_W = way_width(WAYS);

   logic [WAY_W-1:0] age_q [SETS][WAYS];
   logic             found;

   // Touched way becomes age 0; only ways younger than it age by one, so the
   // ages of a set stay a permutation of 0..WAYS-1.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               age_q[s][w] <= WAY_W'(w);
      end else if (upd_i) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == way_i)
               age_q[set_i][w] <= '0;
            else if (age_q[set_i][w] < age_q[set_i][way_i])
               age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
         end
      end
   end

   always_comb begin
      victim_o = '0;
      found    = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found && !valid_i[w]) begin
            victim_o = WAY_W'(w);
            found    = 1'b1;
         end
      end
      if (!found) begin
         for (int w = 0; w < WAYS; w++)
            if (age_q[set_i][w] == WAY_W'(WAYS - 1)) victim_o = WAY_W'(w);
      end
   end

endmodule

// File: rtl/dcache_sa_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_sa_ctrl
// N-way set-associative, write-back, write-allocate data cache with true-LRU
// replacement between the CPU MEM stage and a 256-bit data memory. One miss
// outstanding at a time; hits complete with zero latency.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (aborts any miss in flight)
//   bus    : dcache_sa_ctrl_if.slave (p1_* CPU side, mem_* memory side)
//   perf_hit_o/perf_miss_o/perf_wb_o : saturating event counters, present only
//            when the macro DCACHE_PERF_CNT_EN is defined
// Parameters: ADDR_W, LINE_W, SETS, WAYS.
// -----------------------------------------------------------------------------
module dcache_sa_ctrl
   import dcache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int SETS   = 32,
   parameter int WAYS   = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   dcache_sa_ctrl_if.slave  bus
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [31:0]      perf_hit_o,
   output logic [31:0]      perf_miss_o,
   output logic [31:0]      perf_wb_o
`endif
);
   localparam int OFFSET_W = clog2(LINE_W / 8);
   localparam int INDEX_W  = clog2(SETS);
   localparam int WAY_W    = way_width(WAYS);
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
   localparam int WSEL_W   = OFFSET_W - 2;

   state_e            state_q;
   logic              mem_en_q, mem_wr_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [LINE_W-1:0] victim_line_q;
   logic [WAY_W-1:0]  victim_q, victim_w, hit_way, lru_way;

   logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
   logic [LINE_W-1:0] line_q [SETS][WAYS];
   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];

   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] req_idx;
   logic [WSEL_W-1:0]  word_sel;
   logic [WAYS-1:0]    hit_vec;
   logic [LINE_W-1:0]  hit_line;
   logic               req, hit, store_hit, fill_done, lru_upd;

   assign req_tag  = TAG_W'(addr_field(64'(bus.p1_addr_i), INDEX_W + OFFSET_W, TAG_W));
   assign req_idx  = INDEX_W'(addr_field(64'(bus.p1_addr_i), OFFSET_W, INDEX_W));
   assign word_sel = WSEL_W'(addr_field(64'(bus.p1_addr_i), 2, WSEL_W));
   assign req      = bus.p1_MemRead_i | bus.p1_MemWrite_i;

   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         hit_vec[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
         if (hit_vec[w]) hit_way = WAY_W'(w);
      end
   end

   assign hit       = |hit_vec;
   assign hit_line  = line_q[req_idx][hit_way];
   assign store_hit = req & hit & bus.p1_MemWrite_i;
   assign fill_done = (state_q == ST_REFILL) && bus.mem_ack_i;
   assign lru_upd   = (req & hit) | fill_done;
   assign lru_way   = fill_done ? victim_q : hit_way;

   assign bus.p1_stall_o   = req & ~hit;
   assign bus.p1_data_o    = (req & hit) ? hit_line[32*word_sel +: 32] : 32'd0;
   assign bus.mem_enable_o = mem_en_q;
   assign bus.mem_write_o  = mem_wr_q;
   assign bus.mem_addr_o   = mem_addr_q;
   assign bus.mem_data_o   = victim_line_q;

   dcache_lru_age #(.SETS(SETS), .WAYS(WAYS)) u_lru (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .upd_i    (lru_upd),
      .set_i    (req_idx),
      .way_i    (lru_way),
      .valid_i  (valid_q[req_idx]),
      .victim_o (victim_w)
   );

   // Miss sequencing; memory request outputs are registered here.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         mem_en_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
         victim_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (req && !hit) state_q <= ST_MISS;
            ST_MISS: begin
               victim_q <= victim_w;
               mem_en_q <= 1'b1;
               if (valid_q[req_idx][victim_w] && dirty_q[req_idx][victim_w]) begin
                  state_q    <= ST_WRITEBACK;
                  mem_wr_q   <= 1'b1;
                  mem_addr_q <= {tag_q[req_idx][victim_w], req_idx, {OFFSET_W{1'b0}}};
               end else begin
                  state_q    <= ST_REFILL;
                  mem_wr_q   <= 1'b0;
                  mem_addr_q <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
               end
            end
            // Enable stays high across the writeback->refill handover.
            ST_WRITEBACK: if (bus.mem_ack_i) begin
               state_q    <= ST_REFILL;
               mem_wr_q   <= 1'b0;
               mem_addr_q <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
            end
            ST_REFILL: if (bus.mem_ack_i) begin
               state_q  <= ST_FILLED;
               mem_en_q <= 1'b0;
            end
            ST_FILLED: state_q <= ST_IDLE;
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else if (fill_done) begin
         valid_q[req_idx][victim_q] <= 1'b1;
         dirty_q[req_idx][victim_q] <= 1'b0;
      end else if (store_hit) begin
         dirty_q[req_idx][hit_way] <= 1'b1;
      end
   end

   // Tag/data storage carries no reset; validity alone qualifies it.
   always_ff @(posedge clk_i) begin
      if (state_q == ST_MISS) victim_line_q <= line_q[req_idx][victim_w];
      if (fill_done) begin
         line_q[req_idx][victim_q] <= bus.mem_data_i;
         tag_q[req_idx][victim_q]  <= req_tag;
      end else if (store_hit) begin
         line_q[req_idx][hit_way][32*word_sel +: 32] <= bus.p1_data_i;
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   logic [31:0] perf_hit_q, perf_miss_q, perf_wb_q;

   // A hit counts once, in the IDLE cycle where it completes; the completion
   // after a refill belongs to the miss already counted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_hit_q  <= '0;
         perf_miss_q <= '0;
         perf_wb_q   <= '0;
      end else begin
         if (state_q == ST_IDLE && req && hit && perf_hit_q != '1)
            perf_hit_q <= perf_hit_q + 1'b1;
         if (state_q == ST_IDLE && req && !hit && perf_miss_q != '1)
            perf_miss_q <= perf_miss_q + 1'b1;
         if (state_q == ST_WRITEBACK && bus.mem_ack_i && perf_wb_q != '1)
            perf_wb_q <= perf_wb_q + 1'b1;
      end
   end

   assign perf_hit_o  = perf_hit_q;
   assign perf_miss_o = perf_miss_q;
   assign perf_wb_o   = perf_wb_q;
`endif

endmodule

// File: tb/tb_dcache_sa_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_sa_ctrl
// Directed bench for dcache_sa_ctrl (LINE_W=256, SETS=32, WAYS=2). Set 0 tags:
// A=0x000, B=0x400, C=0x800. Memory word w of line L holds 0xA000_0000|L<<8|w.
// -----------------------------------------------------------------------------
module tb_dcache_sa_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dcache_sa_ctrl_if #(.ADDR_W(32), .LINE_W(256)) bus ();

`ifdef DCACHE_PERF_CNT_EN
   logic [31:0] perf_hit, perf_miss, perf_wb;
`endif

   dcache_sa_ctrl #(.ADDR_W(32), .LINE_W(256), .SETS(32), .WAYS(2)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus)
`ifdef DCACHE_PERF_CNT_EN
      ,
      .perf_hit_o  (perf_hit),
      .perf_miss_o (perf_miss),
      .perf_wb_o   (perf_wb)
`endif
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      string       name;
   } vec_t;

   vec_t         vt [6];
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [31:0]  mem [128][8];
   logic [255:0] wb_line;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
      bus.p1_MemRead_i  = rd;
      bus.p1_MemWrite_i = wr;
      bus.p1_addr_i     = addr;
      bus.p1_data_i     = wdata;
   endtask

   // Zero-latency hit: no stall, load data correct, completes at next edge.
   task automatic access_hit(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_data, input string nm);
      drive(~wr, wr, addr, wdata);
      #1;
      check({nm, "_stall"}, 32'(bus.p1_stall_o), 32'd0);
      if (!wr) check({nm, "_data"}, bus.p1_data_o, exp_data);
      tick();
      drive(1'b0, 1'b0, addr, 32'd0);
   endtask

   task automatic req_miss(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input string nm);
      drive(~wr, wr, addr, wdata);
      #1;
      check({nm, "_stall"}, 32'(bus.p1_stall_o), 32'd1);
   endtask

   // Memory side: wait (bounded) for a request, check it, ack after 2 cycles.
   task automatic serve(input logic exp_wr, input logic [31:0] exp_addr, input string nm);
      int         n;
      logic [6:0] ln;
      n = 0;
      while (bus.mem_enable_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({nm, "_en"}, 32'(bus.mem_enable_o), 32'd1);
      check({nm, "_wr"}, 32'(bus.mem_write_o), 32'(exp_wr));
      check({nm, "_addr"}, bus.mem_addr_o, exp_addr);
      ln = bus.mem_addr_o[11:5];
      tick();
      tick();
      if (bus.mem_write_o) begin
         wb_line = bus.mem_data_o;
         for (int w = 0; w < 8; w++) mem[ln][w] = wb_line[32*w +: 32];
      end else begin
         for (int w = 0; w < 8; w++) bus.mem_data_i[32*w +: 32] = mem[ln][w];
      end
      bus.mem_ack_i = 1'b1;
      tick();
      bus.mem_ack_i = 1'b0;
   endtask

   // Cycle after the refill ack: request hits and completes.
   task automatic finish_miss(input logic wr, input logic [31:0] exp_data, input string nm);
      #1;
      check({nm, "_stall"}, 32'(bus.p1_stall_o), 32'd0);
      check({nm, "_en_low"}, 32'(bus.mem_enable_o), 32'd0);
      if (!wr) check({nm, "_data"}, bus.p1_data_o, exp_data);
      tick();
      drive(1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected run to finish");
      $fatal(1);
   end

   initial begin
      int n;
      vt[0] = '{1'b0, 32'h0000_0404, 32'h0,         32'hDEAD_BEEF, "ld_B_w1"};
      vt[1] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0,         "st_A_w2"};
      vt[2] = '{1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678, "ld_A_w2"};
      vt[3] = '{1'b0, 32'h0000_001C, 32'h0,         32'hA000_0007, "ld_A_w7"};
      vt[4] = '{1'b0, 32'h0000_0400, 32'h0,         32'hA000_2000, "ld_B_w0"};
      vt[5] = '{1'b0, 32'h0000_0000, 32'h0,         32'hA000_0000, "ld_A_w0"};
      for (int l = 0; l < 128; l++)
         for (int w = 0; w < 8; w++)
            mem[l][w] = 32'hA000_0000 | (32'(l) << 8) | 32'(w);

      bus.mem_data_i = '0;
      bus.mem_ack_i  = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 32'd0);

      // Reset state
      tick(); tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_en",    32'(bus.mem_enable_o), 32'd0);
      check("rst_wr",    32'(bus.mem_write_o),  32'd0);
      check("rst_addr",  bus.mem_addr_o,        32'd0);
      check("rst_stall", 32'(bus.p1_stall_o),   32'd0);
      check("rst_data",  bus.p1_data_o,         32'd0);
`ifdef DCACHE_PERF_CNT_EN
      check("rst_perf_hit",  perf_hit,  32'd0);
      check("rst_perf_miss", perf_miss, 32'd0);
      check("rst_perf_wb",   perf_wb,   32'd0);
`endif
      tick();

      // 1: cold load of A
      req_miss(1'b0, 32'h0000_0000, 32'd0, "s1");
      serve(1'b0, 32'h0000_0000, "s1_refill");
      finish_miss(1'b0, 32'hA000_0000, "s1_done");

      // 2: store miss allocates B into the free way, then table of hits
      req_miss(1'b1, 32'h0000_0404, 32'hDEAD_BEEF, "s2");
      serve(1'b0, 32'h0000_0400, "s2_refill");
      finish_miss(1'b1, 32'd0, "s2_done");
      for (int i = 0; i < 6; i++)
         access_hit(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp_data, vt[i].name);

      // 3: A is MRU, so C evicts dirty B
      req_miss(1'b0, 32'h0000_0800, 32'd0, "s3");
      serve(1'b1, 32'h0000_0400, "s3_wb");
      check("s3_wb_w0", wb_line[31:0],  32'hA000_2000);
      check("s3_wb_w1", wb_line[63:32], 32'hDEAD_BEEF);
      serve(1'b0, 32'h0000_0800, "s3_refill");
      finish_miss(1'b0, 32'hA000_4000, "s3_done");

      // 4: A still resident; B evicts clean C without writeback
      access_hit(1'b0, 32'h0000_0000, 32'd0, 32'hA000_0000, "s4_ld_A");
      req_miss(1'b0, 32'h0000_0404, 32'd0, "s4");
      serve(1'b0, 32'h0000_0400, "s4_refill");
      finish_miss(1'b0, 32'hDEAD_BEEF, "s4_done");
`ifdef DCACHE_PERF_CNT_EN
      check("perf_hit",  perf_hit,  32'd7);
      check("perf_miss", perf_miss, 32'd4);
      check("perf_wb",   perf_wb,   32'd1);
`endif

      // 5: C evicts dirty A; reset in the middle of the writeback
      req_miss(1'b0, 32'h0000_0800, 32'd0, "s5");
      n = 0;
      while (bus.mem_enable_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("s5_wb_wr",   32'(bus.mem_write_o), 32'd1);
      check("s5_wb_addr", bus.mem_addr_o,       32'h0000_0000);
      check("s5_wb_w2",   bus.mem_data_o[95:64], 32'h1234_5678);
      #3;
      rst = 1'b1;
      #1;
      check("s5_rst_en",   32'(bus.mem_enable_o), 32'd0);
      check("s5_rst_wr",   32'(bus.mem_write_o),  32'd0);
      check("s5_rst_addr", bus.mem_addr_o,        32'd0);
`ifdef DCACHE_PERF_CNT_EN
      check("s5_rst_perf_hit", perf_hit, 32'd0);
`endif
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      req_miss(1'b0, 32'h0000_0008, 32'd0, "s5_after");
      serve(1'b0, 32'h0000_0000, "s5_refill");
      finish_miss(1'b0, 32'hA000_0002, "s5_done");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
